// File: rtl/attack_pkg.sv
// Shared state type, direction codes and beam geometry for the attack controller.
package attack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WINDUP   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } attack_state_t;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int PLAYER_W     = 26;
    localparam int PLAYER_H     = 26;
    localparam int ATTACK_SHORT = 16;
    localparam int ATTACK_LONG  = 80;
    localparam int BEAM_OFFSET  = (PLAYER_W - ATTACK_SHORT) / 2;

    localparam int FRAME_CNT_W  = 8;

    // Screen coordinates are 9 bits; anything past the edge pins to 511.
    function automatic logic [8:0] sat_add9(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return (w_sum >= 10'd511) ? 9'd511 : w_sum[8:0];
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Registered rising-edge detector for the vsync frame clock, one Clk of latency.
module frame_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_frame_clk,
    output logic o_fe
);

    logic r_prev;
    logic r_fe;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
            r_fe   <= 1'b0;
        end else begin
            r_prev <= i_frame_clk;
            r_fe   <= i_frame_clk & ~r_prev;
        end
    end

    assign o_fe = r_fe;

endmodule

// File: rtl/attack_controller.sv
// Frame-timed beam attack sequencer: windup, active beam, cooldown.
// Build option ATTACK_AUTOFIRE_EN: a held key re-fires as soon as cooldown ends.
//
// state       | meaning
// ST_IDLE     | ready, waiting for an armed key press
// ST_WINDUP   | counting frames before the beam turns on
// ST_ACTIVE   | beam live, Attack_On high
// ST_COOLDOWN | beam off, key ignored until the count expires
module attack_controller
    import attack_pkg::*;
#(
    parameter int WINDUP_FRAMES   = 2,
    parameter int ACTIVE_FRAMES   = 4,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Attack_Key,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic [1:0] Player_Direction,
    output logic       Attack_On,
    output logic [8:0] Attack_X,
    output logic [8:0] Attack_Y,
    output logic [1:0] Attack_Dir,
    output logic       Attack_Ready
);

    attack_state_t          r_state;
    attack_state_t          w_next_state;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [FRAME_CNT_W-1:0] w_cnt_inc;
    logic [FRAME_CNT_W-1:0] w_limit;
    logic                   w_fe;
    logic                   w_trigger;
    logic                   w_exit;
    logic                   r_armed;
    logic [8:0]             w_anchor_x;
    logic [8:0]             w_anchor_y;
    logic                   w_on_nxt;
    logic                   w_ready_nxt;
    logic                   r_attack_on;
    logic                   r_attack_ready;
    logic [8:0]             r_attack_x;
    logic [8:0]             r_attack_y;
    logic [1:0]             r_attack_dir;

    frame_edge_detect u_frame_edge (
        .i_clk       (Clk),
        .i_reset     (Reset),
        .i_frame_clk (frame_clk),
        .o_fe        (w_fe)
    );

    assign w_trigger = (r_state == ST_IDLE) && Attack_Key && r_armed;
    assign w_cnt_inc = r_frame_cnt + 1'b1;

    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_WINDUP:   w_limit = FRAME_CNT_W'(WINDUP_FRAMES);
            ST_ACTIVE:   w_limit = FRAME_CNT_W'(ACTIVE_FRAMES);
            ST_COOLDOWN: w_limit = FRAME_CNT_W'(COOLDOWN_FRAMES);
            default:     w_limit = '0;
        endcase
    end

    // A zero-length phase leaves on its entry Clk without waiting for a frame.
    assign w_exit = (w_limit == '0) || (w_fe && (w_cnt_inc == w_limit));

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_trigger) w_next_state = ST_WINDUP;
            ST_WINDUP:   if (w_exit)    w_next_state = ST_ACTIVE;
            ST_ACTIVE:   if (w_exit)    w_next_state = ST_COOLDOWN;
            ST_COOLDOWN: if (w_exit)    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_on_nxt    = (w_next_state == ST_ACTIVE);
        w_ready_nxt = (w_next_state == ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset || (w_next_state != r_state)) r_frame_cnt <= '0;
        else if (w_fe && (r_state != ST_IDLE))  r_frame_cnt <= w_cnt_inc;
    end

    always_ff @(posedge Clk) begin
        if (Reset)            r_armed <= 1'b0;
        else if (w_trigger)   r_armed <= 1'b0;
        else if (!Attack_Key) r_armed <= 1'b1;
`ifdef ATTACK_AUTOFIRE_EN
        else if ((r_state == ST_COOLDOWN) && (w_next_state == ST_IDLE)) r_armed <= 1'b1;
`endif
    end

    always_comb begin
        w_anchor_x = Player_X;
        w_anchor_y = Player_Y;
        case (Player_Direction)
            DIR_DOWN: begin
                w_anchor_x = sat_add9(Player_X, 9'(BEAM_OFFSET));
                w_anchor_y = sat_add9(Player_Y, 9'(PLAYER_H));
            end
            DIR_LEFT: w_anchor_y = sat_add9(Player_Y, 9'(BEAM_OFFSET));
            DIR_UP:   w_anchor_x = sat_add9(Player_X, 9'(BEAM_OFFSET));
            default: begin
                w_anchor_x = sat_add9(Player_X, 9'(PLAYER_W));
                w_anchor_y = sat_add9(Player_Y, 9'(BEAM_OFFSET));
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_attack_on    <= 1'b0;
            r_attack_ready <= 1'b1;
            r_attack_x     <= '0;
            r_attack_y     <= '0;
            r_attack_dir   <= '0;
        end else begin
            r_attack_on    <= w_on_nxt;
            r_attack_ready <= w_ready_nxt;
            if (w_trigger) begin
                r_attack_x   <= w_anchor_x;
                r_attack_y   <= w_anchor_y;
                r_attack_dir <= Player_Direction;
            end
        end
    end

    assign Attack_On    = r_attack_on;
    assign Attack_Ready = r_attack_ready;
    assign Attack_X     = r_attack_x;
    assign Attack_Y     = r_attack_y;
    assign Attack_Dir   = r_attack_dir;

endmodule

// File: tb/tb_attack_controller.sv
// Bench for attack_controller: frame-count reference model plus directed scenarios.
module tb_attack_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_clk;
    logic       key;
    logic       key0;
    logic [8:0] px;
    logic [8:0] py;
    logic [1:0] pdir;

    logic       att_on, att_ready;
    logic [8:0] att_x, att_y;
    logic [1:0] att_dir;
    logic       w0_on, w0_ready;
    logic [8:0] w0_x, w0_y;
    logic [1:0] w0_dir;

    int checks = 0;
    int errors = 0;
    int n_rises = 0;
    int fcnt = 0;

    always #5 clk = ~clk;

    attack_controller dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .Attack_Key(key),
        .Player_X(px), .Player_Y(py), .Player_Direction(pdir),
        .Attack_On(att_on), .Attack_X(att_x), .Attack_Y(att_y),
        .Attack_Dir(att_dir), .Attack_Ready(att_ready)
    );

    attack_controller #(.WINDUP_FRAMES(0)) dut_w0 (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .Attack_Key(key0),
        .Player_X(px), .Player_Y(py), .Player_Direction(pdir),
        .Attack_On(w0_on), .Attack_X(w0_x), .Attack_Y(w0_y),
        .Attack_Dir(w0_dir), .Attack_Ready(w0_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame clock: 20 Clk period, 50% duty, changes 2 time units after the edge.
    initial begin
        frame_clk = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            fcnt = (fcnt + 1) % 20;
            if (fcnt == 0) begin
                frame_clk = 1'b1;
                n_rises++;
            end else if (fcnt == 10) begin
                frame_clk = 1'b0;
            end
        end
    end

    // Reference model: one running count of frame edges since the trigger.
    // Beam is on for counts [2,6), the attack is over when the count reaches 16.
    bit m_valid = 1'b0;
    bit m_busy, m_armed, m_fe, m_prev, m_on, m_ready, m_fe_now, m_trig;
    int m_n, m_x, m_y, m_dir, ax, ay;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_armed = 1'b0; m_fe = 1'b0; m_prev = 1'b0;
            m_n = 0; m_x = 0; m_y = 0; m_dir = 0;
        end else begin
            m_fe_now = m_fe;
            m_trig = !m_busy && key && m_armed;
            if (m_trig) begin
                m_busy = 1'b1;
                m_n = 0;
                m_armed = 1'b0;
                case (int'(pdir))
                    0:       begin ax = int'(px) + 5;  ay = int'(py) + 26; end
                    1:       begin ax = int'(px);      ay = int'(py) + 5;  end
                    2:       begin ax = int'(px) + 5;  ay = int'(py);      end
                    default: begin ax = int'(px) + 26; ay = int'(py) + 5;  end
                endcase
                m_x = (ax > 511) ? 511 : ax;
                m_y = (ay > 511) ? 511 : ay;
                m_dir = int'(pdir);
            end else begin
                if (!key) m_armed = 1'b1;
                if (m_busy && m_fe_now) begin
                    m_n++;
                    if (m_n == 16) begin
                        m_busy = 1'b0;
`ifdef ATTACK_AUTOFIRE_EN
                        m_armed = 1'b1;
`endif
                    end
                end
            end
            m_fe = frame_clk && !m_prev;
            m_prev = frame_clk;
        end
        m_on = m_busy && (m_n >= 2) && (m_n < 6);
        m_ready = !m_busy;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_on",    int'(att_on),    int'(m_on));
            chk("model_ready", int'(att_ready), int'(m_ready));
            chk("model_x",     int'(att_x),     m_x);
            chk("model_y",     int'(att_y),     m_y);
            chk("model_dir",   int'(att_dir),   m_dir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_mid();
        int n = 0;
        tick();
        while (fcnt != 5 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_on(input logic v, input int maxc);
        int n = 0;
        @(negedge clk);
        while (att_on !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_attack_on", int'(att_on), int'(v));
    endtask

    task automatic wait_ready(input logic v, input int maxc);
        int n = 0;
        @(negedge clk);
        while (att_ready !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_attack_ready", int'(att_ready), int'(v));
    endtask

    task automatic pulse_key();
        key = 1'b1;
        tick();
        key = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, r3, nrise, last_rise, gap;
        bit prev_on, fired;

        rst = 1'b1; key = 1'b0; key0 = 1'b0; px = 9'd0; py = 9'd0; pdir = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",    int'(att_ready), 1);
        chk("reset_on",       int'(att_on),    0);
        chk("reset_x",        int'(att_x),     0);
        chk("reset_y",        int'(att_y),     0);
        chk("reset_dir",      int'(att_dir),   0);
        chk("reset_w0_ready", int'(w0_ready),  1);

        // Default timing and down anchor
        wait_mid();
        px = 9'd100; py = 9'd200; pdir = 2'd0;
        r0 = n_rises;
        pulse_key();
        wait_on(1'b1, 200);
        r1 = n_rises;
        chk("down_x",   int'(att_x),   105);
        chk("down_y",   int'(att_y),   226);
        chk("down_dir", int'(att_dir), 0);
        chk("windup_frames", r1 - r0, 2);
        wait_on(1'b0, 200);
        r2 = n_rises;
        chk("active_frames", r2 - r1, 4);
        wait_ready(1'b1, 400);
        r3 = n_rises;
        chk("cooldown_frames", r3 - r2, 10);

        // Right with saturation
        wait_mid();
        px = 9'd500; py = 9'd100; pdir = 2'd3;
        pulse_key();
        wait_on(1'b1, 200);
        chk("right_sat_x", int'(att_x),   511);
        chk("right_y",     int'(att_y),   105);
        chk("right_dir",   int'(att_dir), 3);
        wait_ready(1'b1, 500);

        // Player moves during the beam
        wait_mid();
        px = 9'd100; py = 9'd200; pdir = 2'd0;
        pulse_key();
        wait_on(1'b1, 200);
        tick();
        px = 9'd150; py = 9'd40; pdir = 2'd2;
        repeat (30) tick();
        @(negedge clk);
        chk("frozen_x",   int'(att_x),   105);
        chk("frozen_y",   int'(att_y),   226);
        chk("frozen_dir", int'(att_dir), 0);
        wait_ready(1'b1, 500);
        chk("frozen_x_after", int'(att_x), 105);

        // Key held continuously
        wait_mid();
        px = 9'd20; py = 9'd30; pdir = 2'd1;
        key = 1'b1;
        nrise = 0; last_rise = 0; gap = 16; prev_on = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (att_on && !prev_on) begin
                if (nrise > 0) gap = n_rises - last_rise;
                last_rise = n_rises;
                nrise++;
            end
            prev_on = att_on;
        end
        key = 1'b0;
`ifdef ATTACK_AUTOFIRE_EN
        chk("held_attack_count", nrise, 3);
`else
        chk("held_attack_count", nrise, 1);
`endif
        chk("held_attack_period", gap, 16);
        wait_ready(1'b1, 500);

        // Reset during the beam with the key held
        wait_mid();
        px = 9'd100; py = 9'd200; pdir = 2'd0;
        key = 1'b1;
        wait_on(1'b1, 200);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_on",    int'(att_on),    0);
        chk("rst_mid_ready", int'(att_ready), 1);
        chk("rst_mid_x",     int'(att_x),     0);
        tick();
        rst = 1'b0;
        fired = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!att_ready) fired = 1'b1;
        end
        chk("held_after_reset_fired", int'(fired), 0);
        tick();
        key = 1'b0;
        tick();
        pulse_key();
        wait_ready(1'b0, 5);
        wait_ready(1'b1, 500);

        // Zero-length windup: beam on the 2nd Clk after the trigger
        wait_mid();
        px = 9'd100; py = 9'd200; pdir = 2'd0;
        key0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("w0_on_clk1",    int'(w0_on),    0);
        chk("w0_ready_clk1", int'(w0_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("w0_on_clk2", int'(w0_on), 1);
        chk("w0_x",       int'(w0_x),   105);
        chk("w0_y",       int'(w0_y),   226);
        key0 = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
